prog_loader: RTL and testbench

Writable program store and loader that replaces the fixed instruction ROM feeding the 4-bit CPU controller. A host pushes instruction nibbles over a valid/ready stream. The block writes them sequentially into an 8-entry program memory and holds the CPU in reset while loading. The CPU's program counter reads the memory through a combinational read port, so this block is the writer end of the instruction-fetch interface.

---
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Writable 8-word instruction store: loads a program from a valid/ready stream
// and holds the CPU in reset until a session completes. Optional macro: CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          cpu_rstn_o,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DONE  = 3'd2,
`ifdef CHECKSUM_EN
        CHECK = 3'd4,
`endif
        ERR   = 3'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cpu_rstn_q, cpu_rstn_d;
    logic          wr_en;
    logic          hs;
    logic [DW-1:0] mem_q [DEPTH];
`ifdef CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        hs      = in_valid & in_ready_q;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = ERR;
                end else if (hs) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
                    if (cnt_q[AW-1:0] == AW'(DEPTH - 1)) state_d = CHECK;
`else
                    if (cnt_q[AW-1:0] == AW'(DEPTH - 1)) state_d = DONE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            // Trailing checksum word is compared only, never stored
            CHECK: begin
                if (abort) begin
                    state_d = ERR;
                end else if (hs) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef CHECKSUM_EN
        in_ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
        in_ready_d = (state_d == LOAD);
`endif
        busy_d     = in_ready_d;
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_rstn_d = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_rstn_q <= cpu_rstn_d;
`ifdef CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Program memory: cleared by reset, written sequentially during LOAD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[cnt_q[AW-1:0]] <= in_data;
        end
    end

    assign rd_data    = mem_q[rd_addr];
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_rstn_o = cpu_rstn_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a session-level model.
module tb_prog_loader;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 4;

    logic          clk = 1'b0;
    logic          rstn, start, abort, in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          cpu_rstn_o, busy, done, err;
    logic [AW:0]   word_cnt;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .cpu_rstn_o(cpu_rstn_o),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Session-level model: a program image plus session flags
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    bit            m_busy, m_chk, m_done, m_err, m_rel;
    logic [DW-1:0] m_sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_cnt = 0; m_busy = 0; m_chk = 0; m_done = 0; m_err = 0; m_rel = 0; m_sum = '0;
    endtask

    task automatic model_edge(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
        if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_chk = 0; m_cnt = 0; m_done = 0; m_err = 0; m_sum = '0;
            end
        end else if (a) begin
            m_busy = 0; m_err = 1;
        end else if (v) begin
            if (!m_chk) begin
                m_mem[m_cnt] = d;
                m_cnt++;
                m_sum ^= d;
                if (m_cnt == int'(DEPTH)) begin
`ifdef CHECKSUM_EN
                    m_chk = 1;
`else
                    m_busy = 0; m_done = 1;
`endif
                end
            end else begin
                m_busy = 0;
                if (d == m_sum) m_done = 1; else m_err = 1;
            end
        end
        m_rel = 1;
    endtask

    task automatic check_outs();
        check("in_ready", 32'(in_ready), 32'(m_busy));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("cpu_rstn", 32'(cpu_rstn_o), 32'(m_rel && !m_busy && !m_err));
        check("word_cnt", 32'(word_cnt), 32'(m_cnt));
        check("rd_data", 32'(rd_data), 32'(m_mem[rd_addr]));
    endtask

    // One clock: drive at the previous edge + 1, check read-before-write, then outputs after the edge
    task automatic step(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
        start = s; abort = a; in_valid = v; in_data = d;
        rd_addr = ($urandom_range(1, 0) == 1) ? AW'(m_cnt) : AW'($urandom);
        #1 check("rd_pre", 32'(rd_data), 32'(m_mem[rd_addr]));
        @(posedge clk);
        model_edge(s, a, v, d);
        #1 check_outs();
    endtask

    task automatic dump_mem();
        start = 0; abort = 0; in_valid = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_addr = AW'(i);
            #1 check("mem", 32'(rd_data), 32'(m_mem[i]));
        end
    endtask

    task automatic do_reset();
        start = 0; abort = 0; in_valid = 0;
        #2 rstn = 1'b0;
        #1 model_reset();
        check_outs();
        dump_mem();
        @(negedge clk);
        rstn = 1'b1;
        #1 check("cpu_rstn_pre_edge", 32'(cpu_rstn_o), 32'd0);
        step(0, 0, 0, '0);
        check("cpu_rstn_rel", 32'(cpu_rstn_o), 32'd1);
    endtask

    task automatic load_all(input logic [DW-1:0] base, input logic [DW-1:0] sumword, input bit gaps);
        step(1, 0, 0, '0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (gaps) step(0, 0, 0, DW'($urandom));
            step(0, 0, 1, base + DW'(i));
        end
`ifdef CHECKSUM_EN
        if (gaps) step(0, 0, 0, DW'($urandom));
        step(0, 0, 1, sumword);
`else
        if (sumword == '1) step(0, 0, 0, '0);
`endif
    endtask

    initial begin
        rstn = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0; rd_addr = '0;
        model_reset();
        #3 check_outs();
        dump_mem();
        @(negedge clk);
        rstn = 1'b1;
        #1 check("cpu_rstn_pre_edge", 32'(cpu_rstn_o), 32'd0);
        step(0, 0, 0, '0);
        check("cpu_rstn_rel", 32'(cpu_rstn_o), 32'd1);

        // Back-to-back load of 1..8 (XOR checksum = 8)
        load_all(4'd1, 4'h8, 0);
        check("load_done", 32'(done), 32'd1);
        check("load_cnt", 32'(word_cnt), 32'd8);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_addr = AW'(i);
            #1 check("load_mem", 32'(rd_data), 32'(i + 1));
        end

        // Same load with idle gaps between words
        load_all(4'd1, 4'h8, 1);
        check("gap_done", 32'(done), 32'd1);
        dump_mem();

`ifdef CHECKSUM_EN
        // Bad checksum keeps the CPU in reset, memory intact
        load_all(4'd1, 4'h3, 0);
        check("bad_sum_err", 32'(err), 32'd1);
        check("bad_sum_done", 32'(done), 32'd0);
        check("bad_sum_cpu", 32'(cpu_rstn_o), 32'd0);
        dump_mem();
`endif

        // Abort after three words, with a coincident handshake discarded
        step(1, 0, 0, '0);
        step(0, 0, 1, 4'hA);
        step(0, 0, 1, 4'hB);
        step(0, 0, 1, 4'hC);
        step(0, 1, 1, 4'hD);
        check("abort_err", 32'(err), 32'd1);
        check("abort_cnt", 32'(word_cnt), 32'd3);
        rd_addr = 3'd3;
        #1 check("abort_nowrite", 32'(rd_data), 32'd4);
        dump_mem();
        step(1, 0, 0, '0);
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // Start mid-load is ignored, then reset in the middle of the session
        for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(i + 5));
        step(1, 0, 1, 4'hE);
        check("start_ignored_cnt", 32'(word_cnt), 32'd6);
        do_reset();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(199, 0) == 0) do_reset();
            else step($urandom_range(11, 0) == 0, $urandom_range(39, 0) == 0,
                      $urandom_range(2, 0) != 0, DW'($urandom));
        end
        dump_mem();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
